sprite_compositor: RTL and testbench



---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sprite_dir_fsm.sv | 52 +++++
 rtl/sprite_compositor.sv | 178 +++++++++++++++++
 tb/tb_sprite_compositor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: direction encoding,
// 12-bit colour type, per-channel keyboard map and the reversal helper.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef logic [11:0] rgb12_t;

    localparam int MAX_CH = 4;

    // Indexed [channel][direction]; direction order matches dir_t encoding.
    localparam logic [7:0] KEYMAP [MAX_CH][4] = '{
        '{8'h1A, 8'h04, 8'h16, 8'h07},   // W A S D
        '{8'h52, 8'h50, 8'h51, 8'h4F},   // arrows up/left/down/right
        '{8'h0C, 8'h0D, 8'h0E, 8'h0F},   // I J K L
        '{8'h60, 8'h5C, 8'h5A, 8'h5E}    // keypad 8 4 2 6
    };

    // Opposite direction differs only in the upper bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/sprite_dir_fsm.sv
// Per-channel direction state machine: detects keycode edges, matches them
// against this channel's key map and updates the direction, optionally
// refusing a direct 180-degree turn.
module sprite_dir_fsm
    import sprite_pkg::*;
#(
    parameter int CH         = 0,
    parameter bit NO_REVERSE = 1'b1
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [7:0] i_keycode,
    output dir_t       o_dir
);

    logic [7:0] r_prev_key;
    dir_t       r_dir;
    dir_t       w_dir_next;
    dir_t       w_cand;
    logic       w_match;

    // State register plus one-cycle keycode history for edge detection.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_prev_key <= 8'h00;
            r_dir      <= DIR_UP;
        end else begin
            r_prev_key <= i_keycode;
            r_dir      <= w_dir_next;
        end
    end

    // Next direction: only a fresh key that maps to a different, permitted direction.
    always_comb begin
        w_match    = 1'b0;
        w_cand     = r_dir;
        w_dir_next = r_dir;
        for (int d = 0; d < 4; d++) begin
            if (i_keycode == KEYMAP[CH][d]) begin
                w_match = 1'b1;
                w_cand  = dir_t'(d[1:0]);
            end
        end
        if (w_match && (i_keycode != r_prev_key) && (w_cand != r_dir) &&
            !(NO_REVERSE && (w_cand == opposite(r_dir)))) begin
            w_dir_next = w_cand;
        end
    end

    assign o_dir = r_dir;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite pixel compositor: per-channel hit test and ROM addressing in
// stage 1, a ROM-latency alignment shift register, then priority merge over
// the background with transparency and a per-frame overlap flag in stage 2.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          N_CH       = 2,
    parameter int          DIM        = 24,
    parameter int          ROM_LAT    = 1,
    parameter logic [11:0] TRANSP_KEY = 12'hF0F,
    parameter bit          NO_REVERSE = 1'b1,
    localparam int         ADDR_W     = 2 + $clog2(DIM * DIM)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [7:0]               keycode,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic                     blank,
    input  logic [N_CH*10-1:0]       pos_x,
    input  logic [N_CH*10-1:0]       pos_y,
    output logic [N_CH*ADDR_W-1:0]   rom_addr,
    input  logic [N_CH*12-1:0]       rom_rgb,
    input  logic [11:0]              bg_rgb,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue,
    output logic [N_CH*2-1:0]        dir,
    output logic                     collide
);

    localparam int CW   = $clog2(DIM);
    localparam int PW   = $clog2(DIM * DIM);
    localparam int HALF = DIM / 2;

    logic                w_frame_start;
    logic [N_CH-1:0]     w_hit;
    logic [N_CH-1:0]     w_opaque;

    // Stage-1 flags plus ROM_LAT alignment stages; index ROM_LAT meets rom_rgb.
    logic [N_CH-1:0]     r_hit_pipe [ROM_LAT+1];
    logic [ROM_LAT:0]    r_blank_pipe;
    logic [ROM_LAT:0]    r_fs_pipe;

    logic [N_CH-1:0]     w_hit_al;
    logic                w_blank_al;
    logic                w_fs_al;

    rgb12_t              w_sel_rgb;
    logic                w_seen;
    logic                w_multi;
    logic                w_coll;

    rgb12_t              r_rgb;
    logic                r_collide;
    logic                r_acc;

    assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            dir_t              w_dir;
            dir_t              r_dir_frame;
            dir_t              w_dir_eff;
            logic [11:0]       w_off_x;
            logic [11:0]       w_off_y;
            logic [PW-1:0]     w_pix;
            logic [ADDR_W-1:0] r_rom_addr;

            sprite_dir_fsm #(
                .CH         (gi),
                .NO_REVERSE (NO_REVERSE)
            ) u_dir_fsm (
                .clk        (Clk),
                .srst       (Reset),
                .i_keycode  (keycode),
                .o_dir      (w_dir)
            );

            // Offsets are 12-bit two's complement so left/top clipping never wraps.
            assign w_off_x = {2'b00, DrawX} - {2'b00, pos_x[gi*10 +: 10]} + 12'(HALF);
            assign w_off_y = {2'b00, DrawY} - {2'b00, pos_y[gi*10 +: 10]} + 12'(HALF);
            assign w_hit[gi] = !w_off_x[11] && (w_off_x[10:0] < 11'(DIM)) &&
                               !w_off_y[11] && (w_off_y[10:0] < 11'(DIM));
            assign w_pix = PW'(32'(w_off_y[CW-1:0]) * DIM + 32'(w_off_x[CW-1:0]));

            // The frame-start pixel already belongs to the new frame, so it uses the freshly latched image.
            assign w_dir_eff = w_frame_start ? w_dir : r_dir_frame;

            // Frame image latch and ROM address register (held when the sprite is not hit).
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_dir_frame <= DIR_UP;
                    r_rom_addr  <= '0;
                end else begin
                    if (w_frame_start) begin
                        r_dir_frame <= w_dir;
                    end
                    if (w_hit[gi]) begin
                        r_rom_addr <= {w_dir_eff, w_pix};
                    end
                end
            end

            assign rom_addr[gi*ADDR_W +: ADDR_W] = r_rom_addr;
            assign dir[gi*2 +: 2]                = w_dir;
            assign w_opaque[gi] = w_hit_al[gi] && (rom_rgb[gi*12 +: 12] != TRANSP_KEY);
        end
    endgenerate

    // Stage-1 flag registers and the shift register that waits out the ROM latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                r_hit_pipe[k] <= '0;
            end
            r_blank_pipe <= '0;
            r_fs_pipe    <= '0;
        end else begin
            r_hit_pipe[0]   <= w_hit;
            r_blank_pipe[0] <= blank;
            r_fs_pipe[0]    <= w_frame_start;
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_hit_pipe[k]   <= r_hit_pipe[k-1];
                r_blank_pipe[k] <= r_blank_pipe[k-1];
                r_fs_pipe[k]    <= r_fs_pipe[k-1];
            end
        end
    end

    assign w_hit_al   = r_hit_pipe[ROM_LAT];
    assign w_blank_al = r_blank_pipe[ROM_LAT];
    assign w_fs_al    = r_fs_pipe[ROM_LAT];

    // Priority pick (lowest opaque channel wins) and two-or-more-opaque detection.
    always_comb begin
        w_sel_rgb = bg_rgb;
        w_seen    = 1'b0;
        w_multi   = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_sel_rgb = rom_rgb[i*12 +: 12];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (w_opaque[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
        w_coll = w_multi && w_blank_al;
    end

    // Output colour register and per-frame collision accumulator.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rgb     <= '0;
            r_collide <= 1'b0;
            r_acc     <= 1'b0;
        end else begin
            r_rgb <= w_blank_al ? w_sel_rgb : 12'h000;
            if (w_fs_al) begin
                r_collide <= r_acc;
                r_acc     <= w_coll;
            end else if (w_coll) begin
                r_acc <= 1'b1;
            end
        end
    end

    assign red     = r_rgb[11:8];
    assign green   = r_rgb[7:4];
    assign blue    = r_rgb[3:0];
    assign collide = r_collide;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: direction keys, addressing, colour
// merge, transparency, collision and clipping. Colour expectations are queued
// at issue time and popped by a monitor when the pixel leaves the pipeline.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int N_CH    = 2;
    localparam int DIM     = 24;
    localparam int ROM_LAT = 1;
    localparam int L       = ROM_LAT + 2;
    localparam int AW      = 2 + $clog2(DIM * DIM);

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           keycode;
    logic [9:0]           draw_x;
    logic [9:0]           draw_y;
    logic                 blank;
    logic [N_CH*10-1:0]   pos_x;
    logic [N_CH*10-1:0]   pos_y;
    logic [N_CH*AW-1:0]   rom_addr;
    logic [N_CH*AW-1:0]   rom_addr_nr;
    logic [N_CH*12-1:0]   rom_rgb;
    logic [11:0]          bg_rgb;
    logic [11:0]          bg_d1;
    logic [3:0]           red, green, blue;
    logic [3:0]           red_nr, green_nr, blue_nr;
    logic [N_CH*2-1:0]    dir;
    logic [N_CH*2-1:0]    dir_nr;
    logic                 collide;
    logic                 collide_nr;
    logic [11:0]          ch_color [N_CH];

    exp_t                 exp_q [$];
    logic                 issue = 1'b0;
    logic [L-1:0]         vld_sr = '0;
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    sprite_compositor #(
        .N_CH(N_CH), .DIM(DIM), .ROM_LAT(ROM_LAT), .TRANSP_KEY(12'hF0F), .NO_REVERSE(1'b1)
    ) dut (
        .Clk(clk), .Reset(rst), .keycode(keycode), .DrawX(draw_x), .DrawY(draw_y),
        .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .rom_addr(rom_addr),
        .rom_rgb(rom_rgb), .bg_rgb(bg_rgb), .red(red), .green(green), .blue(blue),
        .dir(dir), .collide(collide)
    );

    sprite_compositor #(
        .N_CH(N_CH), .DIM(DIM), .ROM_LAT(ROM_LAT), .TRANSP_KEY(12'hF0F), .NO_REVERSE(1'b0)
    ) dut_nr (
        .Clk(clk), .Reset(rst), .keycode(keycode), .DrawX(draw_x), .DrawY(draw_y),
        .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .rom_addr(rom_addr_nr),
        .rom_rgb(rom_rgb), .bg_rgb(bg_rgb), .red(red_nr), .green(green_nr), .blue(blue_nr),
        .dir(dir_nr), .collide(collide_nr)
    );

    function automatic logic [11:0] bg_of(input int x, input int y);
        return {x[5:0], y[5:0]};
    endfunction

    // ROM models: one-cycle sprite ROM returning a per-channel colour, background delayed to align.
    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            rom_rgb[i*12 +: 12] <= ch_color[i];
        end
        bg_d1  <= bg_of(int'(draw_x), int'(draw_y));
        bg_rgb <= bg_d1;
    end

    always @(posedge clk) vld_sr <= {vld_sr[L-2:0], issue};

    // Monitor: compare composited colour whenever an issued pixel emerges.
    always @(negedge clk) begin
        if (vld_sr[L-1]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rgb_underflow got %h%h%h want queued entry", red, green, blue);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({red, green, blue} !== e.rgb) begin
                    errors++;
                    $display("FAIL rgb (%0d,%0d) got %h want %h", e.x, e.y, {red, green, blue}, e.rgb);
                end else begin
                    $display("pix (%0d,%0d) rgb %h ok", e.x, e.y, e.rgb);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end else begin
            $display("chk %s = %h ok", name, got);
        end
    endtask

    task automatic pix(input int x, input int y, input logic b, input logic [11:0] e);
        exp_t t;
        @(posedge clk); #1;
        draw_x = 10'(x);
        draw_y = 10'(y);
        blank  = b;
        issue  = 1'b1;
        t.x = x; t.y = y; t.rgb = e;
        exp_q.push_back(t);
    endtask

    task automatic park();
        @(posedge clk); #1;
        issue  = 1'b0;
        draw_x = 10'd700;
        draw_y = 10'd500;
        blank  = 1'b0;
    endtask

    task automatic idle(input int n);
        park();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] k);
        park();
        keycode = k;
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        logic [1:0] prev;

        rst = 1'b1; keycode = 8'h00; blank = 1'b0; draw_x = 10'd700; draw_y = 10'd500;
        pos_x = {10'd500, 10'd100};
        pos_y = {10'd400, 10'd100};
        ch_color[0] = 12'h0F0;
        ch_color[1] = 12'h00F;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_rgb", 32'({red, green, blue}), 32'h0);
        check("reset_dir", 32'(dir), 32'h0);
        check("reset_collide", 32'(collide), 32'h0);
        check("reset_addr", 32'(rom_addr), 32'h0);
        check("reset_nr", 32'({red_nr, green_nr, blue_nr, dir_nr, collide_nr, rom_addr_nr}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Direction state machine.
        key(8'h1A); check("dir_W_same", 32'(dir[1:0]), 32'h0);
        key(8'h07); check("dir_D", 32'(dir[1:0]), 32'h3);
        check("dir_nr_D", 32'(dir_nr[1:0]), 32'h3);
        key(8'h04); check("dir_A_reject", 32'(dir[1:0]), 32'h3);
        check("dir_nr_A", 32'(dir_nr[1:0]), 32'h1);
        key(8'h1A); check("dir_W_up", 32'(dir[1:0]), 32'h0);
        @(posedge clk); #1;
        keycode = 8'h07;
        cnt  = 0;
        prev = dir[1:0];
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (dir[1:0] != prev) cnt++;
            prev = dir[1:0];
        end
        check("hold_updates", 32'(cnt), 32'd1);
        check("hold_dir", 32'(dir[1:0]), 32'h3);
        key(8'h00);
        key(8'h07); check("repress_same", 32'(dir[1:0]), 32'h3);
        key(8'h4F); check("ch1_right", 32'(dir[3:2]), 32'h3);
        key(8'h00);

        // Frame start latches both images as right; address checks.
        pix(0, 0, 1'b1, 12'h000);
        pix(88, 88, 1'b1, 12'h0F0); park();
        check("addr_88_88", 32'(rom_addr[AW-1:0]), 32'hC00);
        pix(111, 111, 1'b1, 12'h0F0); park();
        check("addr_111_111", 32'(rom_addr[AW-1:0]), 32'hE3F);

        // Colour scan around the sprite edges.
        for (int yi = 0; yi < 5; yi++) begin
            int ys [5] = '{87, 88, 100, 111, 112};
            for (int x = 86; x <= 113; x++) begin
                int y;
                y = ys[yi];
                pix(x, y, 1'b1, (x >= 88 && x <= 111 && y >= 88 && y <= 111) ? 12'h0F0 : bg_of(x, y));
            end
        end
        pix(87, 100, 1'b1, bg_of(87, 100));
        idle(L);

        // Mid-frame key: image only changes after the next frame start.
        key(8'h16); check("dir_S", 32'(dir[1:0]), 32'h2);
        key(8'h00);
        pix(88, 88, 1'b1, 12'h0F0); park();
        check("addr_midframe", 32'(rom_addr[AW-1:0]), 32'hC00);
        pix(0, 0, 1'b1, 12'h000);
        pix(88, 88, 1'b1, 12'h0F0); park();
        check("addr_newframe", 32'(rom_addr[AW-1:0]), 32'h800);
        idle(L);

        // Overlap: ch1 at (110,100); ch0 has priority.
        pos_x = {10'd110, 10'd100};
        pos_y = {10'd100, 10'd100};
        pix(0, 0, 1'b1, 12'h000);
        for (int x = 96; x <= 113; x++) begin
            pix(x, 100, 1'b1, (x <= 111) ? 12'h0F0 : 12'h00F);
        end
        pix(100, 100, 1'b0, 12'h000);
        idle(L + 1);
        check("collide_before_fs", 32'(collide), 32'h0);
        pix(0, 0, 1'b1, 12'h000);
        idle(L);
        check("collide_set", 32'(collide), 32'h1);

        // Transparent ch0 over opaque ch1: ch1 shows, no collision next frame.
        ch_color[0] = 12'hF0F;
        idle(3);
        for (int x = 96; x <= 113; x++) begin
            pix(x, 100, 1'b1, (x >= 98) ? 12'h00F : bg_of(x, 100));
        end
        pix(0, 0, 1'b1, 12'h000);
        idle(L);
        check("collide_clear", 32'(collide), 32'h0);

        // Left-edge clipping: no wrap to the right side of the line.
        ch_color[0] = 12'h0F0;
        pos_x = {10'd500, 10'd5};
        pos_y = {10'd400, 10'd100};
        idle(3);
        for (int k = 0; k < 7; k++) begin
            int xs [7] = '{0, 1, 16, 17, 20, 1012, 1023};
            pix(xs[k], 100, 1'b1, (xs[k] <= 16) ? 12'h0F0 : bg_of(xs[k], 100));
        end
        idle(L + 3);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
